// File: rtl/start_done_seq_pkg.sv
// rtl/start_done_seq_pkg.sv - shared types and widths for the start/done sequencer
// Purpose: sequencer state encoding, default counter widths, watchdog-disable value.
// Ports: none (package).
// Optional build macro used by the top: SEQ_CYCLE_COUNT_EN.
package start_done_seq_pkg;

  localparam int CNT_W        = 16;
  localparam int TMO_W        = 12;
  localparam int GAP_W        = 8;
  localparam int TMO_DISABLED = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_DONE = 3'd2,
    S_GAP       = 3'd3,
    S_FINISH    = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

endpackage

// File: rtl/seq_down_timer.sv
// rtl/seq_down_timer.sv - loadable down counter with an expiry strobe
// Purpose: counts enabled cycles down from a loaded value.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   load, load_value load the counter (load wins over enable)
//   enable           decrement while nonzero
//   expired          high in the enabled cycle that takes the count from 1 to 0,
//                    so a load of N expires in the N-th enabled cycle
module seq_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = enable && (count == WIDTH'(1));

endmodule

// File: rtl/start_done_sequencer.sv
// rtl/start_done_sequencer.sv - runs a start/done datapath a programmed number of times
// Purpose: per run, pulse start, wait for a done rising edge under a watchdog,
//          then idle for a programmable gap. Optional macro SEQ_CYCLE_COUNT_EN
//          adds a saturating busy-cycle counter output total_cycles.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   go, abort       sequence request (IDLE/ERROR only) and highest-priority stop
//   num_runs        runs per sequence, captured on accepted go
//   timeout_cycles  watchdog limit per run, 0 disables, captured on go
//   gap_cycles      idle cycles between runs, captured on go
//   start           registered one-cycle start pulse
//   done            datapath completion level (rising edge counts)
//   busy            high in LAUNCH, WAIT_DONE, GAP
//   runs_done       completed runs of the current/last sequence
//   seq_done        one-cycle pulse when all runs are complete
//   timeout_err     sticky watchdog expiry flag
//   total_cycles    (SEQ_CYCLE_COUNT_EN only) busy cycles of the current/last sequence
module start_done_sequencer #(
  parameter int CNT_W = start_done_seq_pkg::CNT_W,
  parameter int TMO_W = start_done_seq_pkg::TMO_W,
  parameter int GAP_W = start_done_seq_pkg::GAP_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_runs,
  input  logic [TMO_W-1:0] timeout_cycles,
  input  logic [GAP_W-1:0] gap_cycles,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] runs_done,
  output logic             seq_done,
  output logic             timeout_err
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]      total_cycles
`endif
);

  import start_done_seq_pkg::*;

  state_t           state, state_nxt;
  logic             done_q;
  logic             done_rise;
  logic [CNT_W-1:0] num_cfg;
  logic [TMO_W-1:0] tmo_cfg;
  logic [GAP_W-1:0] gap_cfg;
  logic             go_ok, go_run, go_zero;
  logic [CNT_W-1:0] runs_inc;
  logic             last_run;
  logic             tmo_en;
  logic             wdog_exp;
  logic             gap_exp;

  assign done_rise = done & ~done_q;
  // abort shadows go; go is only heard when nothing is in flight
  assign go_ok     = go && !abort && ((state == S_IDLE) || (state == S_ERROR));
  assign go_run    = go_ok && (num_runs != '0);
  assign go_zero   = go_ok && (num_runs == '0);
  assign runs_inc  = runs_done + 1'b1;
  assign last_run  = (runs_inc == num_cfg);
  assign tmo_en    = (tmo_cfg != TMO_W'(TMO_DISABLED));
  assign busy      = (state == S_LAUNCH) || (state == S_WAIT_DONE) || (state == S_GAP);

  seq_down_timer #(.WIDTH(TMO_W)) u_wdog (
    .clk        (clk),
    .rst        (rst),
    .load       (state == S_LAUNCH),
    .load_value (tmo_cfg),
    .enable     (state == S_WAIT_DONE),
    .expired    (wdog_exp)
  );

  // Reloaded every WAIT_DONE cycle so the count is fresh on entry to GAP
  seq_down_timer #(.WIDTH(GAP_W)) u_gap (
    .clk        (clk),
    .rst        (rst),
    .load       (state == S_WAIT_DONE),
    .load_value (gap_cfg),
    .enable     (state == S_GAP),
    .expired    (gap_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (go_run) state_nxt = S_LAUNCH;
        end
        S_LAUNCH: begin
          state_nxt = S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          // a done edge in the expiry cycle still counts as a completed run
          if (done_rise) begin
            if (last_run)              state_nxt = S_FINISH;
            else if (gap_cfg == '0)    state_nxt = S_LAUNCH;
            else                       state_nxt = S_GAP;
          end else if (tmo_en && wdog_exp) begin
            state_nxt = S_ERROR;
          end
        end
        S_GAP: begin
          if (gap_exp) state_nxt = S_LAUNCH;
        end
        S_FINISH: begin
          state_nxt = S_IDLE;
        end
        S_ERROR: begin
          if (go_run)       state_nxt = S_LAUNCH;
          else if (go_zero) state_nxt = S_IDLE;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      start       <= 1'b0;
      seq_done    <= 1'b0;
      runs_done   <= '0;
      timeout_err <= 1'b0;
      num_cfg     <= '0;
      tmo_cfg     <= '0;
      gap_cfg     <= '0;
    end else begin
      done_q   <= done;
      // outputs are registered from the next state so they align with it
      start    <= (state_nxt == S_LAUNCH);
      seq_done <= (state_nxt == S_FINISH) || go_zero;
      if (go_run) begin
        num_cfg     <= num_runs;
        tmo_cfg     <= timeout_cycles;
        gap_cfg     <= gap_cycles;
        runs_done   <= '0;
        timeout_err <= 1'b0;
      end else begin
        if (go_zero && (state == S_ERROR)) timeout_err <= 1'b0;
        if ((state == S_WAIT_DONE) && !abort && done_rise) runs_done <= runs_inc;
        if ((state == S_WAIT_DONE) && (state_nxt == S_ERROR)) timeout_err <= 1'b1;
      end
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_cycles <= '0;
    end else if (go_ok) begin
      total_cycles <= '0;
    end else if (busy && (total_cycles != '1)) begin
      total_cycles <= total_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/start_done_sequencer.md
Name: start_done_sequencer

Overview:
Controller that sequences a start/done datapath through a programmed number of runs. For each run it:
- issues a one-cycle start pulse;
- waits for the datapath's done rising edge, guarded by a timeout watchdog;
- inserts a programmable idle gap before the next run.

It sits between the test/config layer and any block with a start/done handshake, and replaces the hand-written stimulus used to bring such datapaths up.

Parameters:
CNT_W, 16, width of run count and run counter
TMO_W, 12, width of timeout counter
GAP_W, 8, width of inter-run gap counter

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
go  input  1  one-cycle request to begin a sequence; ignored while busy
abort  input  1  stop the sequence immediately; highest priority
num_runs  input  CNT_W  runs per sequence; captured on accepted go
timeout_cycles  input  TMO_W  WAIT_DONE watchdog limit; 0 disables; captured on go
gap_cycles  input  GAP_W  idle cycles between runs; captured on go
start  output  1  registered one-cycle start pulse to datapath
done  input  1  datapath completion level; only its rising edge counts
busy  output  1  high in LAUNCH, WAIT_DONE, GAP
runs_done  output  CNT_W  completed runs in current/last sequence
seq_done  output  1  one-cycle pulse when all runs complete
timeout_err  output  1  sticky; set on watchdog expiry

Behaviour:
Reset values:
- state=IDLE; all outputs 0; done_q=0.

Done edge:
- done_q registers done every cycle.
- done_rise = done & ~done_q.

States:
- IDLE:
  - go with num_runs!=0: capture config, clear runs_done and timeout_err, go to LAUNCH.
  - go with num_runs==0: pulse seq_done next cycle, stay IDLE.
- LAUNCH: start=1 for exactly this cycle. Load the watchdog with timeout_cycles, go to WAIT_DONE. A done_rise in LAUNCH is ignored.
- WAIT_DONE:
  - done_rise: runs_done+1.
    - If the new count equals num_runs, go to FINISH.
    - Otherwise go to GAP; if gap_cycles==0, go straight to LAUNCH.
  - Watchdog enabled and counter reaches 0 without done_rise: go to ERROR, set timeout_err.
  - done_rise in the expiry cycle wins over the timeout.
- GAP: count gap_cycles cycles, then go to LAUNCH.
- FINISH: seq_done=1 for one cycle, then go to IDLE.
- ERROR: busy=0, timeout_err held. Leave only via go (restarts sequence, clears timeout_err) or abort (to IDLE, timeout_err held).

Abort:
- In any state, abort goes to IDLE next cycle.
- start is forced 0 in that cycle; no seq_done; runs_done is held.
- go in the same cycle as abort is ignored.

Latency and arithmetic:
- go accepted at edge k: start high in cycle k+1.
- done_rise at edge j: next start no earlier than edge j+1+gap_cycles.
- runs_done never wraps: the sequence ends when it equals num_runs, so max runs is 2^CNT_W-1.
- Unsigned counters. Watchdog counts T cycles after entering WAIT_DONE.
- Input changes while busy have no effect until the next go.

Reset mid-operation:
- Immediate return to IDLE with reset values; start is never glitched.

Optional Feature:
SEQ_CYCLE_COUNT_EN
- Defined: adds output total_cycles [31:0].
  - Cleared on accepted go; increments every cycle busy=1; saturates at all-ones.
  - Holds after the sequence ends.
- Undefined: port and counter are absent; no other behaviour changes.

Decomposition:
Package start_done_seq_pkg holds:
- state enum (IDLE, LAUNCH, WAIT_DONE, GAP, FINISH, ERROR);
- default widths CNT_W/TMO_W/GAP_W;
- localparam TMO_DISABLED=0.

Sub-module seq_down_timer (load, enable, expired; parameterised width) is used twice, for watchdog and gap. Shared-package localparams set the width of each instance.

Test Plan:
1. num_runs=3, gap=2, timeout=0; done rises 5 cycles after each start. Expect 3 start pulses, each spaced 1+5+2 cycles from the previous pulse; runs_done=3; one seq_done; busy falls with seq_done.
2. num_runs=2, timeout=10; done never rises. Expect 1 start; timeout_err=1 exactly 10 cycles after WAIT_DONE entry; runs_done=0; no seq_done.
3. done held high from before go, num_runs=2. Expect no completion until done falls and rises again.
4. Simultaneous done_rise and watchdog expiry (timeout=4, done rises in 4th cycle). Expect the run counted and timeout_err=0.
5. abort during GAP of run 2 of 5. Expect IDLE next cycle, busy=0, start=0, runs_done=2, no seq_done. A later go restarts with runs_done cleared.
6. num_runs=0 go. Expect seq_done pulse, busy never high, no start. Also assert rst mid-WAIT_DONE and expect all outputs 0 asynchronously.
